// File: rtl/tpu_pkg.sv
// Shared types and widths for the systolic array datapath.
package tpu_pkg;

  localparam int unsigned PSUM_W = 24;
  localparam int unsigned DATA_W = 8;

  typedef logic signed [PSUM_W-1:0] psum_t;

endpackage

// File: rtl/psum_fifo.sv
// Synchronous circular-buffer FIFO for aligned partial-sum row vectors.
// A push into a full FIFO only lands when a pop frees a slot in the same cycle.
module psum_fifo #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = empty ? '0 : mem[rptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= ptr_next(wptr);
      if (rd_en) rptr <= ptr_next(rptr);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Bottom-edge collector of the PE array: removes the column skew from the
// partial sums, queues each aligned row and serves it on valid/ready.
module psum_drain
  import tpu_pkg::*;
#(
  parameter int unsigned COLS  = 4,
  parameter int unsigned PW    = PSUM_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [COLS*PW-1:0]         in_psum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*PW-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       stall_req,
  output logic                       overflow
);

  localparam int unsigned VW = COLS * PW;

  logic [COLS-2:0] vsr;
  logic [VW-1:0]   push_vec;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [31:0]     inflight;

  // Row-valid shift register; the last tap marks the cycle the row is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsr <= '0;
    end else begin
      vsr[0] <= in_valid;
      for (int i = 1; i < int'(COLS) - 1; i++) begin
        vsr[i] <= vsr[i-1];
      end
    end
  end

  assign push = vsr[COLS-2];

  // Column c is delayed COLS-1-c cycles so every column meets the last one.
  for (genvar c = 0; c < int'(COLS) - 1; c++) begin : g_dsk
    localparam int unsigned NS = COLS - 1 - c;
    logic [PW-1:0] stg [NS];

    // Bit-exact delay line for this column.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(NS); i++) stg[i] <= '0;
      end else begin
        stg[0] <= in_psum[c*PW +: PW];
        for (int i = 1; i < int'(NS); i++) stg[i] <= stg[i-1];
      end
    end

    assign push_vec[c*PW +: PW] = stg[NS-1];
  end

  // The last column is already aligned and is taken live from the input.
  assign push_vec[(COLS-1)*PW +: PW] = in_psum[(COLS-1)*PW +: PW];

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  psum_fifo #(
    .W     (VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_vec),
    .dout  (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Stall once queued plus in-flight rows could fill the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(COLS) - 1; i++) begin
      inflight = inflight + 32'(vsr[i]);
    end
    stall_req = (32'(count) + inflight) >= 32'(DEPTH);
  end

  // Sticky drop flag: a completed row found the FIFO full with no pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: the stimulus side queues expected rows,
// a negedge monitor checks every accepted output and handshake stability.
module tb_psum_drain;

  localparam int unsigned COLS  = 4;
  localparam int unsigned PW    = 24;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned VW    = COLS * PW;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_psum = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_data;
  logic [CW-1:0] count;
  logic          stall_req;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] expq [$];
  logic [VW-1:0] hist [COLS];

  logic          held = 1'b0;
  logic [VW-1:0] held_data = '0;

  psum_drain #(
    .COLS  (COLS),
    .PW    (PW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_psum   (in_psum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .stall_req (stall_req),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] mk(input logic [PW-1:0] c0, input logic [PW-1:0] c1,
                                       input logic [PW-1:0] c2, input logic [PW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // One array cycle: column c carries the row issued c cycles ago.
  task automatic cyc(input logic v, input logic [VW-1:0] row, input logic rdy, input logic ex);
    @(posedge clk);
    #1;
    for (int c = COLS - 1; c > 0; c--) hist[c] = hist[c-1];
    hist[0] = v ? row : {COLS{24'hABCDEF}};
    for (int c = 0; c < int'(COLS); c++) in_psum[c*PW +: PW] = hist[c][c*PW +: PW];
    in_valid  = v;
    out_ready = rdy;
    if (v && ex) expq.push_back(row);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2, 1'b0);
    rst = 1'b0;
  endtask

  // Monitor: compare each accepted row and check hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", VW'(out_valid), VW'(1'b1));
        chk("hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_row: got=%h want=none", out_data);
        end else begin
          chk("row_data", out_data, expq.pop_front());
        end
      end
      held      = out_valid & ~out_ready;
      held_data = out_data;
    end
  end

  initial begin
    logic [15:0] pat;
    pat = 16'b0110_1001_1100_0101;
    for (int c = 0; c < int'(COLS); c++) hist[c] = '0;

    // Reset state
    idle(2, 1'b0);
    @(negedge clk);
    chk("rst_count", VW'(count), '0);
    chk("rst_valid", VW'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_ovf", VW'(overflow), '0);
    chk("rst_stall", VW'(stall_req), '0);
    rst = 1'b0;

    // 1: single row, out_valid exactly at t+4
    cyc(1'b1, mk(24'd1, 24'd2, 24'd3, 24'd4), 1'b1, 1'b1);
    idle(3, 1'b1);
    @(negedge clk);
    chk("t1_valid_t3", VW'(out_valid), '0);
    idle(1, 1'b1);
    @(negedge clk);
    chk("t1_valid_t4", VW'(out_valid), VW'(1'b1));
    chk("t1_data", out_data, 96'h000004_000003_000002_000001);
    idle(1, 1'b1);
    @(negedge clk);
    chk("t1_valid_t5", VW'(out_valid), '0);
    chk("t1_count", VW'(count), '0);

    // 2: signed bit patterns pass untouched
    cyc(1'b1, mk(24'hFFFF9C, 24'h7FFFFF, 24'h800000, 24'h000000), 1'b1, 1'b1);
    idle(4, 1'b1);
    @(negedge clk);
    chk("t2_valid", VW'(out_valid), VW'(1'b1));
    chk("t2_data", out_data, 96'h000000_800000_7FFFFF_FFFF9C);
    idle(2, 1'b1);

    // 3: fill to full, stall timing, forced overflow, ordered drain
    for (int r = 0; r < 8; r++) begin
      cyc(1'b1, mk(PW'(r*10), PW'(r*10+1), PW'(r*10+2), PW'(r*10+3)), 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("t3_stall_c7", VW'(stall_req), '0);
    idle(1, 1'b0);
    @(negedge clk);
    chk("t3_stall_c8", VW'(stall_req), VW'(1'b1));
    idle(4, 1'b0);
    @(negedge clk);
    chk("t3_count_full", VW'(count), VW'(8));
    chk("t3_ovf_before", VW'(overflow), '0);
    cyc(1'b1, mk(24'd80, 24'd81, 24'd82, 24'd83), 1'b0, 1'b0);
    idle(4, 1'b0);
    @(negedge clk);
    chk("t3_ovf_set", VW'(overflow), VW'(1'b1));
    chk("t3_count_kept", VW'(count), VW'(8));
    chk("t3_head", out_data, 96'h000003_000002_000001_000000);
    idle(9, 1'b1);
    @(negedge clk);
    chk("t3_drained", VW'(count), '0);
    chk("t3_ovf_sticky", VW'(overflow), VW'(1'b1));
    chk("t3_queue", VW'(expq.size()), '0);

    do_reset();
    @(negedge clk);
    chk("rst_clears_ovf", VW'(overflow), '0);

    // 4: full FIFO, push coincides with pop
    for (int r = 0; r < 8; r++) begin
      cyc(1'b1, mk(PW'(r+100), PW'(r+200), PW'(r+300), PW'(r+400)), 1'b0, 1'b1);
    end
    idle(4, 1'b0);
    @(negedge clk);
    chk("t4_count_full", VW'(count), VW'(8));
    cyc(1'b1, mk(24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD), 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    @(negedge clk);
    chk("t4_count_kept", VW'(count), VW'(8));
    chk("t4_no_ovf", VW'(overflow), '0);
    idle(9, 1'b1);
    @(negedge clk);
    chk("t4_drained", VW'(count), '0);
    chk("t4_queue", VW'(expq.size()), '0);

    // 5: reset in the middle of a row
    do_reset();
    cyc(1'b1, mk(24'h111111, 24'h222222, 24'h333333, 24'h444444), 1'b1, 1'b0);
    idle(2, 1'b1);
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      @(negedge clk);
      chk("t5_no_valid", VW'(out_valid), '0);
    end
    chk("t5_count", VW'(count), '0);
    chk("t5_ovf", VW'(overflow), '0);
    cyc(1'b1, mk(24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D), 1'b1, 1'b1);
    idle(3, 1'b1);
    @(negedge clk);
    chk("t5_valid_t3", VW'(out_valid), '0);
    idle(1, 1'b1);
    @(negedge clk);
    chk("t5_valid_t4", VW'(out_valid), VW'(1'b1));
    chk("t5_data", out_data, 96'h0D0D0D_0C0C0C_0B0B0B_0A0A0A);
    idle(2, 1'b1);

    // 6: three back-to-back rows under toggling backpressure
    for (int r = 0; r < 3; r++) begin
      cyc(1'b1, mk(PW'(r+11), PW'(r+22), PW'(r+33), PW'(r+44)), pat[r], 1'b1);
    end
    for (int i = 3; i < 40; i++) cyc(1'b0, '0, pat[i%16], 1'b0);
    idle(2, 1'b1);
    @(negedge clk);
    chk("t6_queue", VW'(expq.size()), '0);
    chk("t6_count", VW'(count), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
# psum_drain

Output collector at the bottom edge of the systolic PE array. It receives the column-skewed 24-bit partial sums leaving the last PE row and removes the skew, so that all columns of one result row line up. Each aligned row vector is buffered in a small FIFO and presented downstream on a valid/ready handshake. It is the receive end of the PE `so` interface: the array produces the sums, and this block consumes them.

## Interface
- `COLS`, default 4: number of array columns.
- `PW`, default 24: partial-sum width, two's complement, equal to the PE `so` width.
- `DEPTH`, default 8: FIFO depth in row vectors. Must be ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: column-0 word of a new row is present this cycle. Validity for column c is in_valid delayed by c cycles, tracked internally.
- `in_psum` in COLS*PW: column c at bits [c*PW +: PW]. Column c carries the word of the row whose column-0 word arrived c cycles earlier.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: downstream accepts the head this cycle.
- `out_data` out COLS*PW: aligned row, with the same column packing as `in_psum`.
- `count` out $clog2(DEPTH+1): number of vectors held in the FIFO.
- `stall_req` out 1: the array must not assert in_valid in this cycle.
- `overflow` out 1: sticky flag. Set when a vector is dropped; cleared only by rst.

## Operation
- **Deskew:**
  - Column c passes through COLS-1-c register stages. Column COLS-1 has zero stages.
  - Data is carried bit-exact, with no sign extension and no arithmetic.
- **Valid tracking:**
  - A shift register of COLS-1 bits is fed by in_valid.
  - `push` = the tap at stage COLS-1. It is asserted in the cycle when column COLS-1 of that row is at the input.
  - When push is asserted, the aligned vector is formed from the deskew outputs plus the live column COLS-1 input.
- **FIFO:**
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - `pop` = out_valid & out_ready.
- **Push with FIFO not full:** the vector is written.
- **Push with FIFO full:**
  - If pop is asserted in the same cycle, the write succeeds and count is unchanged.
  - If pop is not asserted, the new vector is dropped, overflow is set, and FIFO contents are unchanged.
- **Pop with FIFO empty:** impossible, because out_valid is low.
- **Simultaneous push and pop, FIFO not full:** count is unchanged.
- **stall_req:** high when count + (number of set bits in the valid shift register) ≥ DEPTH. It is combinational from registered state only. An array that honours stall_req never causes an overflow.
- **Mid-stream behaviour:** in_valid may be asserted on consecutive cycles. There is no gap requirement between rows.

## Timing
- **Latency:**
  - A row whose column-0 word arrives in cycle t has its column c word arriving in cycle t+c.
  - The vector is pushed at the end of cycle t+COLS-1.
  - If the FIFO was empty, out_valid is high from cycle t+COLS.
- **Throughput:** one row per cycle, both in and out.
- **Handshake:**
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - out_valid never drops without a pop.
- **Reset (rst=1 at a rising edge):**
  - count=0, out_valid=0, out_data=0, overflow=0, stall_req=0.
  - The valid shift register and all deskew registers are cleared.
  - Pointers are set to 0.
  - Rows in flight are discarded and never appear at the output, including rows partially received before rst.
- **During rst:** in_valid and out_ready are ignored.

## Structure
- Shared package `tpu_pkg`:
  - `PSUM_W`=24, `DATA_W`=8.
  - `psum_t` (signed [PSUM_W-1:0]), reused by the PE and the array top.
- Sub-module `psum_fifo`:
  - Parameterised synchronous FIFO (width COLS*PW, depth DEPTH).
  - Outputs: count, full, empty.
  - Same clk/rst scheme as this block.
- The top level holds the deskew generate loop, the valid shift register, the stall and overflow logic, and one `psum_fifo` instance.

## Test plan
All scenarios use COLS=4, PW=24, DEPTH=8.
1. **Single row:** in_valid at cycle 0; col0=1 at cycle 0, col1=2 at cycle 1, col2=3 at cycle 2, col3=4 at cycle 3; out_ready=1 → out_valid only in cycle 4, out_data={4,3,2,1}, count returns to 0.
2. **Signed bit-exactness:** columns -100, 8388607, -8388608, 0 (as 24'hFFFF9C, 24'h7FFFFF, 24'h800000, 24'h0) → the same bit patterns appear on out_data.
3. **Fill to full:** out_ready=0, 8 back-to-back rows (col c = row*10+c) → count=8; stall_req high from the cycle count+inflight reaches 8. Then force a 9th row → overflow=1 and count stays 8. Then out_ready=1 → rows drain in order 0..7 with no 9th row.
4. **Full with simultaneous push and pop:** count=8, out_ready=1 in the push cycle → no overflow, count stays 8, the new row lands last.
5. **Reset mid-row:** in_valid at cycle 0, rst=1 at cycle 2 → out_valid never rises for that row; count=0, overflow=0. A row issued after reset appears correctly at +4 cycles.
6. **Backpressure toggling:** 3 rows with out_ready toggled pseudo-randomly → out_data stable whenever out_valid & !out_ready; all 3 rows are received in order with no duplicates.
